sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It succeeds the fixed-threshold FIFO as the DUT of the class-based testbench. It sits between a single-clock producer and consumer, which observe status through the FIFO interface.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_prog.sv | 134 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, width helpers and default thresholds for the programmable-threshold FIFO.
package fifo_pkg;

  typedef enum logic {
    READ_REG  = 1'b0,
    READ_FWFT = 1'b1
  } read_mode_e;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AE_THRESH = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers index 0..depth-1; keep at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int def_af_thresh(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, flush and
// selectable registered or first-word-fall-through read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int AF_THRESH  = def_af_thresh(FIFO_DEPTH),
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FIFO_WIDTH-1:0]        data_in,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic                         flush,
  output logic [FIFO_WIDTH-1:0]        data_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         almostfull,
  output logic                         empty,
  output logic                         almostempty,
  output logic [cnt_w(FIFO_DEPTH)-1:0] count
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam read_mode_e MODE = (FWFT != 0) ? READ_FWFT : READ_REG;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_ok, rd_ok, mem_we;
  logic [FIFO_WIDTH-1:0] rd_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almostfull  = (count_q >= AF_C) && !full;
  assign almostempty = (count_q <= AE_C) && !empty;

  // Both requests are judged against the flags held at the start of the cycle.
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign mem_we = wr_ok && !flush;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ack_d   = wr_ok;
        overflow_d = !wr_ok;
      end
      if (rd_en) begin
        underflow_d = !rd_ok;
      end
      if (wr_ok) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        data_out_d = rd_data;
      end
      if (wr_ok && !rd_ok) begin
        count_d = count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // FWFT shows the head word directly and drives zero while empty.
  assign data_out  = (MODE == READ_FWFT) ? (empty ? '0 : rd_data) : data_out_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: registered-read FIFO with AF=5/AE=2, and an FWFT FIFO with defaults.
module tb_sync_fifo_prog;

  logic clk;
  logic rst_n;

  logic [15:0] a_din, a_dout;
  logic        a_wr, a_rd, a_flush;
  logic        a_ack, a_ovf, a_udf, a_full, a_af, a_empty, a_ae;
  logic [3:0]  a_cnt;

  logic [15:0] b_din, b_dout;
  logic        b_wr, b_rd, b_flush;
  logic        b_ack, b_ovf, b_udf, b_full, b_af, b_empty, b_ae;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_prog #(
    .FIFO_WIDTH (16), .FIFO_DEPTH (8), .AF_THRESH (5), .AE_THRESH (2), .FWFT (0)
  ) u_reg (
    .clk (clk), .rst_n (rst_n), .data_in (a_din), .wr_en (a_wr), .rd_en (a_rd),
    .flush (a_flush), .data_out (a_dout), .wr_ack (a_ack), .overflow (a_ovf),
    .underflow (a_udf), .full (a_full), .almostfull (a_af), .empty (a_empty),
    .almostempty (a_ae), .count (a_cnt)
  );

  sync_fifo_prog #(
    .FIFO_WIDTH (16), .FIFO_DEPTH (8), .FWFT (1)
  ) u_fwft (
    .clk (clk), .rst_n (rst_n), .data_in (b_din), .wr_en (b_wr), .rd_en (b_rd),
    .flush (b_flush), .data_out (b_dout), .wr_ack (b_ack), .overflow (b_ovf),
    .underflow (b_udf), .full (b_full), .almostfull (b_af), .empty (b_empty),
    .almostempty (b_ae), .count (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_flags(input string tag, input int c);
    chk({tag, ".count"}, 32'(a_cnt), 32'(c));
    chk({tag, ".empty"}, 32'(a_empty), 32'(c == 0));
    chk({tag, ".full"},  32'(a_full),  32'(c == 8));
    chk({tag, ".af"},    32'(a_af),    32'(c >= 5 && c < 8));
    chk({tag, ".ae"},    32'(a_ae),    32'(c >= 1 && c <= 2));
  endtask

  initial begin
    rst_n = 1'b0;
    a_din = '0; a_wr = 0; a_rd = 0; a_flush = 0;
    b_din = '0; b_wr = 0; b_rd = 0; b_flush = 0;
    #12;
    chk("rst.count", 32'(a_cnt), 0);
    chk("rst.empty", 32'(a_empty), 1);
    chk("rst.full", 32'(a_full), 0);
    chk("rst.af", 32'(a_af), 0);
    chk("rst.ae", 32'(a_ae), 0);
    chk("rst.ack", 32'(a_ack), 0);
    chk("rst.ovf", 32'(a_ovf), 0);
    chk("rst.udf", 32'(a_udf), 0);
    chk("rst.dout", 32'(a_dout), 0);
    chk("rst.fwft_dout", 32'(b_dout), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill 0xA000..0xA007; threshold sweep on the way up
    for (int i = 0; i < 8; i++) begin
      a_wr = 1; a_din = 16'hA000 + 16'(i);
      tick();
      $display("write %0d data=%h ack=%0d count=%0d", i, a_din, a_ack, a_cnt);
      chk($sformatf("fill%0d.ack", i), 32'(a_ack), 1);
      chk_a_flags($sformatf("fill%0d", i), i + 1);
    end
    a_din = 16'hFFFF;
    tick();
    $display("write over-full ovf=%0d ack=%0d count=%0d", a_ovf, a_ack, a_cnt);
    chk("ovf.ovf", 32'(a_ovf), 1);
    chk("ovf.ack", 32'(a_ack), 0);
    chk("ovf.count", 32'(a_cnt), 8);
    a_wr = 0;
    tick();
    chk("idle.ovf", 32'(a_ovf), 0);
    chk("idle.ack", 32'(a_ack), 0);

    // Full with both requests: read wins, write rejected
    a_wr = 1; a_rd = 1; a_din = 16'hBEEF;
    tick();
    $display("full wr+rd dout=%h ovf=%0d count=%0d", a_dout, a_ovf, a_cnt);
    chk("fullboth.dout", 32'(a_dout), 32'h0000A000);
    chk("fullboth.ovf", 32'(a_ovf), 1);
    chk("fullboth.udf", 32'(a_udf), 0);
    chk_a_flags("fullboth", 7);

    a_wr = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      $display("read %0d dout=%h count=%0d", i, a_dout, a_cnt);
      chk($sformatf("rd%0d.dout", i), 32'(a_dout), 32'h0000A000 + 32'(i));
      chk($sformatf("rd%0d.udf", i), 32'(a_udf), 0);
      chk_a_flags($sformatf("rd%0d", i), 7 - i);
    end
    tick();
    $display("read empty udf=%0d dout=%h", a_udf, a_dout);
    chk("udf.udf", 32'(a_udf), 1);
    chk("udf.dout", 32'(a_dout), 32'h0000A007);
    chk("udf.count", 32'(a_cnt), 0);

    // Empty with both requests: write wins, read rejected
    a_wr = 1; a_din = 16'h5555;
    tick();
    $display("empty wr+rd ack=%0d udf=%0d count=%0d", a_ack, a_udf, a_cnt);
    chk("emptyboth.udf", 32'(a_udf), 1);
    chk("emptyboth.ack", 32'(a_ack), 1);
    chk("emptyboth.dout", 32'(a_dout), 32'h0000A007);
    chk_a_flags("emptyboth", 1);
    a_wr = 0;
    tick();
    $display("read dout=%h count=%0d", a_dout, a_cnt);
    chk("rd5555.dout", 32'(a_dout), 32'h00005555);
    chk_a_flags("rd5555", 0);
    a_rd = 0;

    // Flush at count 5 with a concurrent write
    a_wr = 1;
    for (int i = 0; i < 5; i++) begin
      a_din = 16'hC000 + 16'(i);
      tick();
    end
    chk("preflush.count", 32'(a_cnt), 5);
    a_flush = 1; a_din = 16'hDEAD;
    tick();
    $display("flush count=%0d empty=%0d ack=%0d", a_cnt, a_empty, a_ack);
    a_flush = 0; a_wr = 0;
    chk("flush.ack", 32'(a_ack), 0);
    chk("flush.dout", 32'(a_dout), 32'h00005555);
    chk_a_flags("flush", 0);
    a_wr = 1; a_din = 16'h7777;
    tick();
    a_wr = 0; a_rd = 1;
    tick();
    a_rd = 0;
    $display("post-flush read dout=%h count=%0d", a_dout, a_cnt);
    chk("postflush.dout", 32'(a_dout), 32'h00007777);
    chk("postflush.count", 32'(a_cnt), 0);

    // FWFT instance
    b_wr = 1; b_din = 16'h1234;
    tick();
    b_wr = 0;
    $display("fwft write dout=%h count=%0d", b_dout, b_cnt);
    chk("fwft.w.dout", 32'(b_dout), 32'h00001234);
    chk("fwft.w.ae", 32'(b_ae), 1);
    tick();
    chk("fwft.hold.dout", 32'(b_dout), 32'h00001234);
    b_rd = 1;
    tick();
    b_rd = 0;
    $display("fwft pop dout=%h empty=%0d", b_dout, b_empty);
    chk("fwft.pop.dout", 32'(b_dout), 0);
    chk("fwft.pop.empty", 32'(b_empty), 1);
    b_wr = 1;
    for (int i = 0; i < 7; i++) begin
      b_din = 16'h1111 * 16'(i + 1);
      tick();
    end
    b_wr = 0;
    $display("fwft fill7 dout=%h count=%0d af=%0d", b_dout, b_cnt, b_af);
    chk("fwft.c7.dout", 32'(b_dout), 32'h00001111);
    chk("fwft.c7.af", 32'(b_af), 1);
    chk("fwft.c7.full", 32'(b_full), 0);
    b_rd = 1;
    tick();
    b_rd = 0;
    $display("fwft pop dout=%h count=%0d", b_dout, b_cnt);
    chk("fwft.pop2.dout", 32'(b_dout), 32'h00002222);
    chk("fwft.pop2.count", 32'(b_cnt), 6);

    // Asynchronous reset mid-burst, checked before the next clock edge
    a_wr = 1;
    for (int i = 0; i < 3; i++) begin
      a_din = 16'hE000 + 16'(i);
      tick();
    end
    a_rd = 1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset count=%0d empty=%0d dout=%h", a_cnt, a_empty, a_dout);
    chk("arst.count", 32'(a_cnt), 0);
    chk("arst.empty", 32'(a_empty), 1);
    chk("arst.ack", 32'(a_ack), 0);
    chk("arst.dout", 32'(a_dout), 0);
    chk("arst.fwft_count", 32'(b_cnt), 0);
    chk("arst.fwft_dout", 32'(b_dout), 0);
    a_wr = 0; a_rd = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst.after.count", 32'(a_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
